// File: rtl/fetch_queue.sv
// Instruction fetch queue: reads sequential words from a fixed-latency ROM
// into a small FIFO, restarting at a new address on redirect.
module fetch_queue #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int LATENCY    = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      redirect,
   input  logic [ADDR_WIDTH-1:0]     redirect_addr,
   input  logic                      pop,
   output logic                      inst_valid,
   output logic [DATA_WIDTH-1:0]     inst_data,
   output logic [ADDR_WIDTH-1:0]     inst_addr,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      rom_chip_enable,
   output logic [ADDR_WIDTH-1:0]     rom_addr,
   input  logic [DATA_WIDTH-1:0]     rom_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [WW-1:0]         LAST_WAIT = WW'(LATENCY - 1);
   localparam logic [CW-1:0]         FULL      = CW'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(DATA_WIDTH / 8);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      STALL
   } state_t;

   state_t                  state;
   state_t                  next_state;

   logic [ADDR_WIDTH-1:0]   fetch_pc;
   logic [WW-1:0]           wait_cnt;
   logic [PW-1:0]           wr_ptr;
   logic [PW-1:0]           rd_ptr;

   logic [DATA_WIDTH-1:0]   mem_data [DEPTH];
   logic [ADDR_WIDTH-1:0]   mem_addr [DEPTH];

   logic                    read_done;
   logic                    push;
   logic                    pop_fire;
   logic [CW-1:0]           count_next;

   // ------------------------------------------------------------------
   // Next-state and queue-control decode
   // ------------------------------------------------------------------
   always_comb begin
      next_state = state;
      read_done  = (state == FETCH) && (wait_cnt == LAST_WAIT);
      push       = read_done && !redirect;
      pop_fire   = pop && (count != '0);
      count_next = count + CW'(push) - CW'(pop_fire);

      case (state)
         IDLE: begin
            next_state = IDLE;
         end
         FETCH: begin
            // Only launch another read if it is guaranteed a free slot.
            if (read_done) begin
               next_state = (count_next < FULL) ? FETCH : STALL;
            end
         end
         STALL: begin
            if (count < FULL) begin
               next_state = FETCH;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase

      if (redirect) begin
         next_state = FETCH;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ------------------------------------------------------------------
   // Fetch address, wait counter and queue pointers
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_pc <= '0;
         wait_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else if (redirect) begin
         // An in-flight read is dropped: its push is masked in the decode.
         fetch_pc <= redirect_addr;
         wait_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            fetch_pc <= fetch_pc + STEP;
            wait_cnt <= '0;
            wr_ptr   <= wr_ptr + PW'(1);
         end else if (state == FETCH) begin
            wait_cnt <= wait_cnt + WW'(1);
         end

         if (pop_fire) begin
            rd_ptr <= rd_ptr + PW'(1);
         end

         count <= count_next;
      end
   end

   // Storage needs no reset: outputs are masked while the queue is empty.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_data[wr_ptr] <= rom_data;
         mem_addr[wr_ptr] <= fetch_pc;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   always_comb begin
      inst_valid      = (count != '0);
      inst_data       = inst_valid ? mem_data[rd_ptr] : '0;
      inst_addr       = inst_valid ? mem_addr[rd_ptr] : '0;
      rom_chip_enable = (state == FETCH);
      rom_addr        = rom_chip_enable ? fetch_pc : '0;
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4, LATENCY=2) against a ROM whose
// word at address A is A ^ 0xA5A5A5A5.
module tb_fetch_queue;

   logic        clock;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic        pop;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_addr;
   logic [2:0]  count;
   logic        rom_chip_enable;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;

   int checks;
   int failures;

   localparam logic [31:0] KEY = 32'hA5A5A5A5;

   fetch_queue #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .DEPTH      (4),
      .LATENCY    (2)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .redirect        (redirect),
      .redirect_addr   (redirect_addr),
      .pop             (pop),
      .inst_valid      (inst_valid),
      .inst_data       (inst_data),
      .inst_addr       (inst_addr),
      .count           (count),
      .rom_chip_enable (rom_chip_enable),
      .rom_addr        (rom_addr),
      .rom_data        (rom_data)
   );

   assign rom_data = rom_addr ^ KEY;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Cycle 0 is the negedge slot where redirect is driven; returns in cycle 1.
   task automatic do_redirect(input logic [31:0] addr);
      redirect      = 1'b1;
      redirect_addr = addr;
      @(negedge clock);
      redirect      = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
      checks++; if (inst_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", inst_data); end
      checks++; if (inst_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", inst_addr); end
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (rom_chip_enable !== 1'b0) begin failures++; $display("FAIL reset_ce got=%b exp=0", rom_chip_enable); end
      checks++; if (rom_addr !== 32'h0) begin failures++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
      repeat (2) @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         checks++; if (rom_chip_enable !== 1'b0) begin failures++; $display("FAIL idle_ce cyc=%0d got=%b exp=0", i, rom_chip_enable); end
      end
   endtask

   task automatic test_fill_and_resume;
      do_redirect(32'h0);
      checks++; if (rom_chip_enable !== 1'b1) begin failures++; $display("FAIL fill_c1_ce got=%b exp=1", rom_chip_enable); end
      checks++; if (rom_addr !== 32'h0) begin failures++; $display("FAIL fill_c1_rom_addr got=%h exp=0", rom_addr); end
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL fill_c1_valid got=%b exp=0", inst_valid); end
      @(negedge clock);
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL fill_c2_valid got=%b exp=0", inst_valid); end
      @(negedge clock);
      checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL fill_c3_valid got=%b exp=1", inst_valid); end
      checks++; if (inst_addr !== 32'h0) begin failures++; $display("FAIL fill_c3_addr got=%h exp=0", inst_addr); end
      checks++; if (inst_data !== 32'hA5A5A5A5) begin failures++; $display("FAIL fill_c3_data got=%h exp=a5a5a5a5", inst_data); end
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL fill_c3_count got=%0d exp=1", count); end
      checks++; if (rom_addr !== 32'h4) begin failures++; $display("FAIL fill_c3_rom_addr got=%h exp=4", rom_addr); end
      repeat (6) @(negedge clock);
      checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_c9_count got=%0d exp=4", count); end
      checks++; if (rom_chip_enable !== 1'b0) begin failures++; $display("FAIL fill_c9_ce got=%b exp=0", rom_chip_enable); end
      checks++; if (inst_addr !== 32'h0) begin failures++; $display("FAIL fill_c9_head got=%h exp=0", inst_addr); end
      for (int c = 10; c <= 12; c++) begin
         @(negedge clock);
         checks++; if (rom_chip_enable !== 1'b0) begin failures++; $display("FAIL full_ce c%0d got=%b exp=0", c, rom_chip_enable); end
         checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count c%0d got=%0d exp=4", c, count); end
      end
      // cycle 12: single pop while full
      pop = 1'b1;
      @(negedge clock);
      pop = 1'b0;
      checks++; if (count !== 3'd3) begin failures++; $display("FAIL resume_c13_count got=%0d exp=3", count); end
      checks++; if (inst_addr !== 32'h4) begin failures++; $display("FAIL resume_c13_head got=%h exp=4", inst_addr); end
      checks++; if (rom_chip_enable !== 1'b0) begin failures++; $display("FAIL resume_c13_ce got=%b exp=0", rom_chip_enable); end
      @(negedge clock);
      checks++; if (rom_chip_enable !== 1'b1) begin failures++; $display("FAIL resume_c14_ce got=%b exp=1", rom_chip_enable); end
      checks++; if (rom_addr !== 32'h10) begin failures++; $display("FAIL resume_c14_rom_addr got=%h exp=10", rom_addr); end
      @(negedge clock);
      checks++; if (count !== 3'd3) begin failures++; $display("FAIL resume_c15_count got=%0d exp=3", count); end
      @(negedge clock);
      checks++; if (count !== 3'd4) begin failures++; $display("FAIL resume_c16_count got=%0d exp=4", count); end
      // drain four entries, one per cycle, checking FIFO order
      for (int i = 0; i < 4; i++) begin
         logic [31:0] ea;
         ea = 32'h4 + 32'(4 * i);
         pop = 1'b1;
         checks++; if (inst_addr !== ea) begin failures++; $display("FAIL drain_addr i=%0d got=%h exp=%h", i, inst_addr, ea); end
         checks++; if (inst_data !== (ea ^ KEY)) begin failures++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, inst_data, ea ^ KEY); end
         @(negedge clock);
      end
      pop = 1'b0;
      // cycle 19 had a push and a pop together
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL pushpop_count got=%0d exp=1", count); end
      checks++; if (inst_addr !== 32'h14) begin failures++; $display("FAIL pushpop_head got=%h exp=14", inst_addr); end
   endtask

   task automatic test_stream;
      pop = 1'b1;
      do_redirect(32'h40);
      for (int k = 1; k <= 16; k++) begin
         logic        ev;
         logic [31:0] ea;
         ev = (k >= 3) && (k % 2 == 1);
         ea = 32'h40 + 32'(2 * (k - 3));
         checks++; if (inst_valid !== ev) begin failures++; $display("FAIL stream_valid c%0d got=%b exp=%b", k, inst_valid, ev); end
         checks++; if (count !== {2'b00, ev}) begin failures++; $display("FAIL stream_count c%0d got=%0d exp=%0d", k, count, ev); end
         if (ev) begin
            checks++; if (inst_addr !== ea) begin failures++; $display("FAIL stream_addr c%0d got=%h exp=%h", k, inst_addr, ea); end
         end
         @(negedge clock);
      end
      pop = 1'b0;
   endtask

   task automatic test_redirect_mid_read;
      do_redirect(32'h0);
      repeat (5) @(negedge clock);
      // cycle 6: second wait cycle of the read at 0x8
      checks++; if (rom_addr !== 32'h8) begin failures++; $display("FAIL mid_c6_rom_addr got=%h exp=8", rom_addr); end
      checks++; if (count !== 3'd2) begin failures++; $display("FAIL mid_c6_count got=%0d exp=2", count); end
      do_redirect(32'h100);
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL mid_c7_count got=%0d exp=0", count); end
      checks++; if (rom_chip_enable !== 1'b1) begin failures++; $display("FAIL mid_c7_ce got=%b exp=1", rom_chip_enable); end
      checks++; if (rom_addr !== 32'h100) begin failures++; $display("FAIL mid_c7_rom_addr got=%h exp=100", rom_addr); end
      @(negedge clock);
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL mid_c8_valid got=%b exp=0", inst_valid); end
      @(negedge clock);
      checks++; if (inst_addr !== 32'h100) begin failures++; $display("FAIL mid_c9_head got=%h exp=100", inst_addr); end
      checks++; if (inst_data !== (32'h100 ^ KEY)) begin failures++; $display("FAIL mid_c9_data got=%h exp=%h", inst_data, 32'h100 ^ KEY); end
      repeat (2) @(negedge clock);
      checks++; if (count !== 3'd2) begin failures++; $display("FAIL mid_c11_count got=%0d exp=2", count); end
      checks++; if (inst_addr !== 32'h100) begin failures++; $display("FAIL mid_c11_head got=%h exp=100", inst_addr); end
   endtask

   task automatic test_wrap_and_empty_pop;
      do_redirect(32'hFFFFFFFC);
      pop = 1'b1;
      @(negedge clock);
      pop = 1'b0;
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL empty_pop_count got=%0d exp=0", count); end
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL empty_pop_valid got=%b exp=0", inst_valid); end
      @(negedge clock);
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL wrap_c3_count got=%0d exp=1", count); end
      checks++; if (inst_addr !== 32'hFFFFFFFC) begin failures++; $display("FAIL wrap_c3_head got=%h exp=fffffffc", inst_addr); end
      checks++; if (inst_data !== 32'h5A5A5A59) begin failures++; $display("FAIL wrap_c3_data got=%h exp=5a5a5a59", inst_data); end
      checks++; if (rom_addr !== 32'h0) begin failures++; $display("FAIL wrap_c3_rom_addr got=%h exp=0", rom_addr); end
      repeat (2) @(negedge clock);
      checks++; if (count !== 3'd2) begin failures++; $display("FAIL wrap_c5_count got=%0d exp=2", count); end
      pop = 1'b1;
      @(negedge clock);
      pop = 1'b0;
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL wrap_c6_count got=%0d exp=1", count); end
      checks++; if (inst_addr !== 32'h0) begin failures++; $display("FAIL wrap_c6_head got=%h exp=0", inst_addr); end
      checks++; if (inst_data !== 32'hA5A5A5A5) begin failures++; $display("FAIL wrap_c6_data got=%h exp=a5a5a5a5", inst_data); end
   endtask

   task automatic test_async_reset;
      do_redirect(32'h0);
      repeat (3) @(negedge clock);
      // cycle 4: one entry held, second read in flight
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL arst_pre_count got=%0d exp=1", count); end
      #3 reset = 1'b0;
      #1;
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", inst_valid); end
      checks++; if (inst_data !== 32'h0) begin failures++; $display("FAIL arst_data got=%h exp=0", inst_data); end
      checks++; if (inst_addr !== 32'h0) begin failures++; $display("FAIL arst_addr got=%h exp=0", inst_addr); end
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL arst_count got=%0d exp=0", count); end
      checks++; if (rom_chip_enable !== 1'b0) begin failures++; $display("FAIL arst_ce got=%b exp=0", rom_chip_enable); end
      checks++; if (rom_addr !== 32'h0) begin failures++; $display("FAIL arst_rom_addr got=%h exp=0", rom_addr); end
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         checks++; if (rom_chip_enable !== 1'b0) begin failures++; $display("FAIL arst_idle_ce i=%0d got=%b exp=0", i, rom_chip_enable); end
         checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL arst_idle_valid i=%0d got=%b exp=0", i, inst_valid); end
      end
      do_redirect(32'h200);
      checks++; if (rom_chip_enable !== 1'b1) begin failures++; $display("FAIL arst_after_ce got=%b exp=1", rom_chip_enable); end
      checks++; if (rom_addr !== 32'h200) begin failures++; $display("FAIL arst_after_rom_addr got=%h exp=200", rom_addr); end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      redirect      = 1'b0;
      redirect_addr = 32'h0;
      pop           = 1'b0;
      test_reset();
      test_fill_and_resume();
      test_stream();
      test_redirect_mid_read();
      test_wrap_and_empty_pop();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the instruction address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the instruction word width; it must be a multiple of 8.
REQ-003 Parameter DEPTH, default 4, SHALL set the queue entry count; it must be a power of 2 and at least 2.
REQ-004 Parameter LATENCY, default 2, SHALL set the ROM read cycles per word; it must be at least 1.
REQ-005 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port redirect, input, 1 bit: when high, restart fetching at redirect_addr.
REQ-008 Port redirect_addr, input, ADDR_WIDTH: the new fetch address.
REQ-009 Port pop, input, 1 bit: the consumer takes the head entry.
REQ-010 Port inst_valid, output, 1 bit: the queue holds at least one entry.
REQ-011 Port inst_data, output, DATA_WIDTH: the head instruction word.
REQ-012 Port inst_addr, output, ADDR_WIDTH: the head instruction address.
REQ-013 Port count, output, clog2(DEPTH)+1 bits: the current entry count.
REQ-014 Port rom_chip_enable, output, 1 bit: the ROM read enable.
REQ-015 Port rom_addr, output, ADDR_WIDTH: the ROM read address.
REQ-016 Port rom_data, input, DATA_WIDTH: the ROM read data.

Function
REQ-017 The FSM SHALL have three states:
- IDLE: no fetch target.
- FETCH: read in flight.
- STALL: queue full.
REQ-018 In IDLE, rom_chip_enable SHALL be 0 and rom_addr 0; the block leaves IDLE only on redirect.
REQ-019 In FETCH:
- rom_chip_enable SHALL be 1.
- rom_addr SHALL equal fetch_pc and stay stable for the whole read.
- A wait counter SHALL count LATENCY cycles.
REQ-020 In the LATENCY-th FETCH cycle of a read, the block SHALL:
- sample rom_data at the clock edge;
- push {fetch_pc, rom_data} at the tail;
- advance fetch_pc by DATA_WIDTH/8, modulo 2^ADDR_WIDTH;
- clear the wait counter.
REQ-021 At most one read SHALL be in flight. A new read starts only when the post-update count is below DEPTH; otherwise the next state is STALL. A read that has started therefore always has room when it completes.
REQ-022 In STALL, rom_chip_enable SHALL be 0. The FSM SHALL return to FETCH in the cycle after count drops below DEPTH, and the read then restarts at fetch_pc.
REQ-023 When inst_valid is 1:
- inst_valid SHALL equal (count != 0);
- inst_data and inst_addr SHALL show the head entry combinationally.
When the queue is empty, inst_data and inst_addr SHALL be 0.
REQ-024 A pop with inst_valid=1 SHALL remove the head at the clock edge. A pop with inst_valid=0 SHALL be ignored, with no underflow.
REQ-025 A push and a pop in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-026 Redirect SHALL take priority over push, pop and every state. In the cycle after redirect:
- the queue SHALL be empty (count=0);
- any in-flight read SHALL be discarded and its data never enqueued;
- the wait counter SHALL be 0;
- fetch_pc SHALL equal redirect_addr;
- the state SHALL be FETCH.
REQ-027 Latency from redirect: redirect in cycle 0 gives rom_chip_enable=1 with rom_addr=redirect_addr in cycle 1, and inst_valid=1 in cycle 1+LATENCY.
REQ-028 Sustained throughput SHALL be one word per LATENCY cycles while the queue is not full.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH, and count SHALL saturate at neither 0 nor DEPTH illegally.

Reset
REQ-030 While reset=0, the block SHALL asynchronously force:
- state IDLE;
- count=0 and pointers 0;
- fetch_pc=0 and wait counter 0;
- inst_valid=0, inst_data=0, inst_addr=0;
- rom_chip_enable=0, rom_addr=0.
REQ-031 A reset asserted mid-read or mid-fill SHALL discard all entries. After release the block SHALL stay in IDLE until redirect.

Verification (DEPTH=4, LATENCY=2, ROM word at address A = A xor 0xA5A5A5A5)
REQ-032 Fill: redirect 0x0 in cycle 0, no pop:
- inst_valid rises in cycle 3 with inst_addr 0x0 and inst_data 0xA5A5A5A5;
- count reaches 4 at cycle 9 holding addresses 0x0, 0x4, 0x8, 0xC;
- rom_chip_enable is 0 from cycle 9 onward.
REQ-033 Stream: redirect 0x40 with pop held high:
- inst_addr runs 0x40, 0x44, 0x48, ..., one entry per 2 cycles;
- count never exceeds 1.
REQ-034 Redirect mid-read: redirect 0x100 in the second wait cycle of the read at 0x8:
- count is 0 the next cycle;
- the next rom_addr is 0x100;
- the data for 0x8 is never emitted.
REQ-035 Wrap and empty pop:
- redirect 0xFFFFFFFC gives queue addresses 0xFFFFFFFC then 0x0;
- pop on an empty queue leaves count at 0.
REQ-036 Full, pop and resume: with count=4, a single pop gives count 3; the next cycle rom_chip_enable=1 with rom_addr 0x10, and count returns to 4 two cycles later.
REQ-037 Async reset: reset driven low mid-fill, off a clock edge, drives all outputs to 0 immediately; after release, no ROM activity occurs until redirect.
